// File: rtl/sram_port_arbiter.sv
// Arbitrates one synchronous single-port SRAM between instruction fetch and the MEM stage.
// MEM has priority. A starvation counter forces a fetch grant after STARVE_LIMIT denied cycles.
module sram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  // 2'b11 is never written; it decodes as no owner because rvalid uses equality.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_MEM  = 2'b10
  } own_t;

  own_t             resp_own;
  logic [CNT_W-1:0] starve_cnt;
  logic             force_i;

  assign force_i = (starve_cnt == LIMIT);
  assign d_gnt   = d_req & ~(force_i & i_req);
  assign i_gnt   = i_req & ~d_gnt;
  assign sram_en = i_gnt | d_gnt;

  always_comb begin
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (d_gnt) begin
      sram_we    = d_we;
      sram_addr  = d_addr;
      sram_wdata = d_wdata;
    end else if (i_gnt) begin
      sram_addr  = i_addr;
    end
  end

  // Grant stage -> response stage: remember who owns next cycle's read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      resp_own   <= OWN_NONE;
    end else begin
      if (i_gnt || !i_req)
        starve_cnt <= '0;
      else if (starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + CNT_W'(1);

      if (i_gnt)
        resp_own <= OWN_IF;
      else if (d_gnt && (d_we == '0))
        resp_own <= OWN_MEM;
      else
        resp_own <= OWN_NONE;
    end
  end

  assign i_rvalid = (resp_own == OWN_IF);
  assign d_rvalid = (resp_own == OWN_MEM);
  assign i_rdata  = sram_rdata;
  assign d_rdata  = sram_rdata;

endmodule
